// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: turns symbolic requests into 32-bit words
// and writes them sequentially into instruction memory from a programmable base.
module instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_last_i,
    input  logic [3:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              imem_we_o,
    input  logic              imem_ready_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  words_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_we;
    logic              r_err;
    logic [CNT_W-1:0]  r_words;

    logic              w_ready;
    logic              w_launch;
    logic              w_accept;
    logic              w_illegal;
    logic              w_issue;
    logic              w_done_wr;
    logic [31:0]       w_word;

    assign w_illegal = (kind_i > 4'd9);
    assign w_done_wr = r_we && imem_ready_i;
    assign w_accept  = req_valid_i && w_ready;
    assign w_issue   = w_accept && !w_illegal;

    always_comb begin
        w_word = 32'h0;
        unique case (kind_i)
            4'd0: w_word = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100000};
            4'd1: w_word = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100010};
            4'd2: w_word = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b011000};
            4'd3: w_word = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100100};
            4'd4: w_word = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100101};
            4'd5: w_word = {6'b001000, rs_i, rt_i, imm_i};
            4'd6: w_word = {6'b100011, rs_i, rt_i, imm_i};
            4'd7: w_word = {6'b101011, rs_i, rt_i, imm_i};
            4'd8: w_word = {6'b000010, target_i};
            4'd9: w_word = {6'b000100, rs_i, rt_i, imm_i};
            default: w_word = 32'h0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_launch = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_launch = start_i;
                if (start_i) w_next = S_RUN;
            end
            S_RUN: begin
                // Single output register; a completing write frees it the same cycle
                w_ready = !r_we || imem_ready_i;
                if (req_valid_i && w_ready) begin
                    if (w_illegal)       w_next = S_ERR;
                    else if (req_last_i) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_we || imem_ready_i) w_next = S_DONE;
            end
            S_DONE: w_next = S_IDLE;
            S_ERR: begin
                w_launch = start_i;
                if (start_i) w_next = S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_next_addr <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= '0;
        end else begin
            r_state <= w_next;
            if (w_launch)
                r_next_addr <= base_addr_i;
            else if (w_issue)
                r_next_addr <= r_next_addr + ADDR_W'(4);
            if (w_issue) begin
                r_we   <= 1'b1;
                r_addr <= r_next_addr;
                r_data <= w_word;
            end else if (w_done_wr) begin
                r_we <= 1'b0;
            end
            if (w_launch)
                r_words <= '0;
            else if (w_done_wr && !(&r_words))
                r_words <= r_words + CNT_W'(1);
            if (w_launch)
                r_err <= 1'b0;
            else if (w_accept && w_illegal)
                r_err <= 1'b1;
        end
    end

    assign req_ready_o = w_ready;
    assign imem_we_o   = r_we;
    assign imem_addr_o = r_addr;
    assign imem_data_o = r_data;
    assign words_o     = r_words;
    assign err_o       = r_err;
    assign done_o      = (r_state == S_DONE);
    assign busy_o      = (r_state == S_RUN) || (r_state == S_DRAIN) ||
                         (r_state == S_ERR);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic        valid = 1'b0;
    logic        ready;
    logic        last = 1'b0;
    logic [3:0]  kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [15:0] imm = '0;
    logic [25:0] tgt = '0;
    logic        we;
    logic        mready = 1'b1;
    logic [31:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];

    instr_encoder dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base),
        .req_valid_i(valid), .req_ready_o(ready), .req_last_i(last),
        .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm),
        .target_i(tgt), .imem_we_o(we), .imem_ready_i(mready),
        .imem_addr_o(addr), .imem_data_o(data), .busy_o(busy),
        .done_o(done), .err_o(err), .words_o(words)
    );

    always #5 clk = ~clk;

    // Record every completed memory write with the cycle it happened on
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && we && mready) begin
            log_addr.push_back(addr);
            log_data.push_back(data);
            log_cyc.push_back(cyc);
        end
    end

    task automatic do_start(input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        base  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after acceptance with valid low
    task automatic push(input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] im,
                        input logic [25:0] tg, input logic l);
        int n;
        kind = k; rs = s; rt = t; rd = d; imm = im; tgt = tg; last = l;
        valid = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL push_timeout kind=%0d got no ready, want ready", k);
        end
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL done_timeout done=%0b want 1", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({ready, we, addr, data, busy, done, err, words} !== 72'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b we=%0b a=%h d=%h busy=%0b done=%0b err=%0b w=%0d want all 0",
                     ready, we, addr, data, busy, done, err, words);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n0;
        n0 = log_addr.size();
        do_start(32'h100);
        checks++;
        if (busy !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL single_run busy=%0b rdy=%0b want 1 1", busy, ready);
        end
        push(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        checks++;
        if (we !== 1'b1 || addr !== 32'h100 || data !== 32'h00221820) begin
            errors++;
            $display("FAIL single_word we=%0b a=%h d=%h want 1 00000100 00221820", we, addr, data);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL single_drain_ready rdy=%0b want 0", ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || words !== 16'd1 || we !== 1'b0) begin
            errors++;
            $display("FAIL single_done done=%0b words=%0d we=%0b want 1 1 0", done, words, we);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || log_addr.size() != n0 + 1) begin
            errors++;
            $display("FAIL single_idle done=%0b busy=%0b nwr=%0d want 0 0 1",
                     done, busy, log_addr.size() - n0);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        logic [31:0] exp_d [5];
        exp_d[0] = 32'h2005FFFF;
        exp_d[1] = 32'h8CA60004;
        exp_d[2] = 32'hACA70008;
        exp_d[3] = 32'h08000040;
        exp_d[4] = 32'h1022FFFE;
        n0 = log_addr.size();
        do_start(32'h200);
        push(4'd5, 5'd0, 5'd5, 5'd0, 16'hFFFF, 26'h0, 1'b0);
        push(4'd6, 5'd5, 5'd6, 5'd0, 16'h0004, 26'h0, 1'b0);
        push(4'd7, 5'd5, 5'd7, 5'd0, 16'h0008, 26'h0, 1'b0);
        push(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040, 1'b0);
        push(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'h0, 1'b1);
        wait_done();
        checks++;
        if (words !== 16'd5 || log_addr.size() != n0 + 5) begin
            errors++;
            $display("FAIL b2b_count words=%0d nwr=%0d want 5 5", words, log_addr.size() - n0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (log_addr[n0+i] !== 32'h200 + 32'(4*i) || log_data[n0+i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL b2b_word%0d a=%h d=%h want %h %h", i, log_addr[n0+i],
                             log_data[n0+i], 32'h200 + 32'(4*i), exp_d[i]);
                end
            end
            checks++;
            if (log_cyc[n0+4] - log_cyc[n0] != 4) begin
                errors++;
                $display("FAIL b2b_rate span=%0d cycles want 4", log_cyc[n0+4] - log_cyc[n0]);
            end
        end
    endtask

    task automatic test_stall();
        int n0;
        n0 = log_addr.size();
        do_start(32'h300);
        mready = 1'b0;
        push(4'd3, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b0);
        kind = 4'd4; rs = 5'd7; rt = 5'd8; rd = 5'd9; last = 1'b1; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ready !== 1'b0 || we !== 1'b1 || addr !== 32'h300 || data !== 32'h00432024) begin
                errors++;
                $display("FAIL stall_hold%0d rdy=%0b we=%0b a=%h d=%h want 0 1 00000300 00432024",
                         i, ready, we, addr, data);
            end
            @(negedge clk);
        end
        mready = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_passthru rdy=%0b want 1", ready);
        end
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        checks++;
        if (we !== 1'b1 || addr !== 32'h304 || data !== 32'h00E84825) begin
            errors++;
            $display("FAIL stall_second we=%0b a=%h d=%h want 1 00000304 00e84825", we, addr, data);
        end
        wait_done();
        checks++;
        if (words !== 16'd2 || log_addr.size() != n0 + 2) begin
            errors++;
            $display("FAIL stall_count words=%0d nwr=%0d want 2 2", words, log_addr.size() - n0);
        end
    endtask

    task automatic test_illegal();
        int n0;
        n0 = log_addr.size();
        do_start(32'h400);
        push(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        push(4'd12, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
        checks++;
        if (err !== 1'b1 || ready !== 1'b0 || busy !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL illegal_state err=%0b rdy=%0b busy=%0b we=%0b want 1 0 1 0", err, ready, busy, we);
        end
        valid = 1'b1;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        checks++;
        if (err !== 1'b1 || log_addr.size() != n0 + 1 || words !== 16'd1) begin
            errors++;
            $display("FAIL illegal_nowrite err=%0b nwr=%0d words=%0d want 1 1 1",
                     err, log_addr.size() - n0, words);
        end
        do_start(32'h500);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || words !== 16'd0) begin
            errors++;
            $display("FAIL illegal_restart err=%0b busy=%0b words=%0d want 0 1 0", err, busy, words);
        end
        push(4'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b1);
        checks++;
        if (addr !== 32'h500 || data !== 32'h00210818) begin
            errors++;
            $display("FAIL illegal_newbase a=%h d=%h want 00000500 00210818", addr, data);
        end
        wait_done();
        checks++;
        if (words !== 16'd1) begin
            errors++;
            $display("FAIL illegal_words words=%0d want 1", words);
        end
    endtask

    task automatic test_async_reset();
        int n0;
        n0 = log_addr.size();
        do_start(32'h600);
        mready = 1'b0;
        push(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
        checks++;
        if (we !== 1'b1 || data !== 32'h00853022) begin
            errors++;
            $display("FAIL rst_pre we=%0b d=%h want 1 00853022", we, data);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, we, addr, data, busy, done, err, words} !== 72'h0) begin
            errors++;
            $display("FAIL rst_async we=%0b a=%h d=%h busy=%0b words=%0d want all 0",
                     we, addr, data, busy, words);
        end
        @(negedge clk);
        rst = 1'b0;
        mready = 1'b1;
        valid = 1'b1;
        kind = 4'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || we !== 1'b0 || log_addr.size() != n0) begin
            errors++;
            $display("FAIL rst_idle rdy=%0b busy=%0b we=%0b nwr=%0d want 0 0 0 0",
                     ready, busy, we, log_addr.size() - n0);
        end
        valid = 1'b0;
    endtask

    task automatic test_wrap();
        int n0;
        n0 = log_addr.size();
        do_start(32'hFFFFFFFC);
        push(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        push(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1);
        wait_done();
        checks++;
        if (log_addr.size() != n0 + 2) begin
            errors++;
            $display("FAIL wrap_count nwr=%0d want 2", log_addr.size() - n0);
        end else if (log_addr[n0] !== 32'hFFFFFFFC || log_addr[n0+1] !== 32'h0 ||
                     log_data[n0+1] !== 32'h00853022) begin
            errors++;
            $display("FAIL wrap_addr a0=%h a1=%h d1=%h want fffffffc 00000000 00853022",
                     log_addr[n0], log_addr[n0+1], log_data[n0+1]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_async_reset();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming MIPS instruction encoder and loader; the inverse of the control decoder.
- Accepts symbolic instruction requests (kind, register fields, immediate, jump target) over a valid/ready handshake.
- Assembles 32-bit MIPS words and writes them sequentially into instruction memory starting at a programmable base address.
- Used by the test harness and boot loader to fill instruction memory before the pipeline is released.

Parameters:
- ADDR_W, 32, width of instruction-memory byte address.
- CNT_W, 16, width of the written-word counter.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- start_i  input  1  one-cycle pulse; begins a load session
- base_addr_i  input  ADDR_W  byte address of first word, sampled on start_i
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when valid && ready
- req_last_i  input  1  marks final request of session
- kind_i  input  4  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 ADDI, 6 LW, 7 SW, 8 J, 9 BEQ; 10-15 illegal
- rs_i, rt_i, rd_i  input  5 each  register fields
- imm_i  input  16  immediate / branch offset
- target_i  input  26  jump target field
- imem_we_o  output  1  write strobe, held until imem_ready_i
- imem_ready_i  input  1  memory accepts write this cycle
- imem_addr_o  output  ADDR_W  write byte address
- imem_data_o  output  32  encoded instruction
- busy_o  output  1  session active
- done_o  output  1  one-cycle pulse after last word written
- err_o  output  1  sticky illegal-kind flag, cleared by start_i
- words_o  output  CNT_W  words written this session

Behaviour:
- Reset (async, rst_i=1): state IDLE; req_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_data_o=0, busy_o=0, done_o=0, err_o=0, words_o=0. Reset mid-session aborts immediately; the pending write is dropped.
- FSM states: IDLE, RUN, DRAIN, DONE, ERR.
- IDLE:
  - start_i: latch next_addr=base_addr_i; clear words_o and err_o; go to RUN.
  - start_i is ignored in all other states except ERR.
- RUN:
  - req_ready_o = !imem_we_o || imem_ready_i (one output register with pass-through on drain).
  - On accept, register the encoded word, imem_addr_o=next_addr, imem_we_o=1 on the next cycle; next_addr += 4 (wraps modulo 2^ADDR_W). Latency is 1 cycle from accept to strobe.
  - Write completes on any edge where imem_we_o && imem_ready_i; words_o increments on that edge (saturates at all-ones).
  - A simultaneous completion and new accept keeps imem_we_o=1 with the new word and address.
  - Accept with req_last_i=1 goes to DRAIN.
- Encoding (fields not listed are 0):
  - R-type: op=000000, rs, rt, rd, shamt=0, func = ADD 100000, SUB 100010, MUL 011000, AND 100100, OR 100101.
  - ADDI: op=001000, rs, rt, imm.
  - LW: op=100011, rs, rt, imm.
  - SW: op=101011, rs, rt, imm.
  - BEQ: op=000100, rs, rt, imm.
  - J: op=000010, target.
- Illegal kind on accept: no write is issued, err_o=1, state goes to ERR. Any in-flight write still completes normally. req_ready_o=0 in ERR.
- DRAIN: req_ready_o=0; once the last write completes, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- ERR: held until start_i, which restarts the session exactly as from IDLE.
- busy_o=1 in RUN, DRAIN and ERR.
- imem_we_o, imem_addr_o and imem_data_o stay stable while imem_we_o=1 and imem_ready_i=0.
- After a write completes with no new accept, imem_we_o drops; data and address keep their last values.

Test Plan:
- start_i with base=0x00000100; single ADD rs=1 rt=2 rd=3 last=1; imem_ready_i=1 -> imem_data_o=0x00221820 at addr 0x100, one cycle after accept; done_o pulses; words_o=1.
- Sequence ADDI rs=0 rt=5 imm=0xFFFF; LW rs=5 rt=6 imm=4; SW; J target=0x0000040; BEQ imm=0xFFFE, back-to-back with ready held high -> words 0x2005FFFF, 0x8CA60004, SW word, 0x08000040, BEQ word at consecutive addresses +4; one write per cycle.
- imem_ready_i low for 3 cycles during a write -> req_ready_o=0; data and address held stable; no lost or duplicated words; words_o correct.
- kind_i=12 mid-session -> no write issued, err_o=1, req_ready_o=0; then start_i -> err_o clears and a new session writes from the new base.
- rst_i asserted while imem_we_o=1 -> all outputs 0 asynchronously, state IDLE; start_i is needed to resume.
- base=0xFFFFFFFC with two requests -> second word address wraps to 0x00000000.
